// File: rtl/udp_burst_pkg.sv
// Shared types and constants for the UDP payload burst generator.
// LFSR taps are only consumed when UDP_BURST_LFSR_EN is defined.
package udp_burst_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_INC   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_TABLE = 2'd3
  } burst_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } burst_state_t;

  localparam logic [15:0] TABLE_WORDS [4] = '{16'hABCD, 16'h6969, 16'hFFFF, 16'h0420};

  // Galois right-shift taps for the supported word widths
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      32:      return 32'h8020_0003;
      default: return 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/udp_burst_gen_pattern.sv
// Payload word generator: load restarts the pattern at word 0, adv steps it.
// LFSR stepping exists only when UDP_BURST_LFSR_EN is defined; otherwise LFSR mode acts as CONST.
module burst_pattern_gen
  import udp_burst_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  burst_mode_t          mode,
  input  logic [DATA_SIZE-1:0] seed,
  input  logic                 load,
  input  logic                 adv,
  output logic [DATA_SIZE-1:0] word
);

  logic [1:0] tbl_idx;

  // Table entries are 16 bits; narrower words truncate, wider words replicate.
  function automatic logic [DATA_SIZE-1:0] tbl_word(input logic [1:0] idx);
    logic [15:0]          t;
    logic [DATA_SIZE-1:0] w;
    t = TABLE_WORDS[idx];
    for (int b = 0; b < DATA_SIZE; b++) w[b] = t[b % 16];
    return w;
  endfunction

`ifdef UDP_BURST_LFSR_EN
  localparam logic [31:0]          TAPS_ALL = lfsr_taps(DATA_SIZE);
  localparam logic [DATA_SIZE-1:0] TAPS     = TAPS_ALL[DATA_SIZE-1:0];

  function automatic logic [DATA_SIZE-1:0] lfsr_step(input logic [DATA_SIZE-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word    <= '0;
      tbl_idx <= 2'd0;
    end else if (load) begin
      tbl_idx <= 2'd0;
      case (mode)
        MODE_TABLE: word <= tbl_word(2'd0);
`ifdef UDP_BURST_LFSR_EN
        MODE_LFSR:  word <= (seed == '0) ? DATA_SIZE'(1) : seed;
`endif
        default:    word <= seed;
      endcase
    end else if (adv) begin
      case (mode)
        MODE_INC: word <= word + DATA_SIZE'(1);
        MODE_TABLE: begin
          tbl_idx <= tbl_idx + 2'd1;
          word    <= tbl_word(tbl_idx + 2'd1);
        end
`ifdef UDP_BURST_LFSR_EN
        MODE_LFSR: word <= lfsr_step(word);
`endif
        default: word <= word;
      endcase
    end
  end

endmodule

// File: rtl/udp_burst_gen.sv
// Burst generator feeding network_stack_tx: start edge -> repeat_n bursts of len words with gaps.
// Optional LFSR pattern mode is enabled by defining UDP_BURST_LFSR_EN.
//   state  | meaning
//   S_IDLE | waiting for a start edge (also the cycle that carries done)
//   S_SEND | driving one word per cycle of the current burst
//   S_GAP  | idle spacing between bursts so the TX stack can close a frame
module udp_burst_gen
  import udp_burst_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int MAX_WORDS  = 64,
  parameter int GAP_CYCLES = 32,
  parameter int LW         = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [LW-1:0]        len,
  input  logic [7:0]           repeat_n,
  input  logic [DATA_SIZE-1:0] seed,
  output logic                 axiov,
  output logic [DATA_SIZE-1:0] axiod,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          burst_count
);

  localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_WORDS);
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  burst_state_t         state, state_nx;
  burst_mode_t          mode_r, mode_nx, pat_mode;
  logic [DATA_SIZE-1:0] seed_r, seed_nx, pat_seed;
  logic [LW-1:0]        len_r, len_nx, len_eff;
  logic [LW-1:0]        word_cnt, word_cnt_nx;
  logic [GW-1:0]        gap_cnt, gap_cnt_nx;
  logic [7:0]           rep_left, rep_nx;
  logic                 start_q, abort_flag, abort_nx;
  logic                 axiov_nx, busy_nx, done_nx;
  logic [15:0]          count_nx;
  logic                 load, adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      mode_r      <= MODE_CONST;
      seed_r      <= '0;
      len_r       <= '0;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      rep_left    <= 8'd0;
      abort_flag  <= 1'b0;
      axiov       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      burst_count <= 16'd0;
    end else begin
      state       <= state_nx;
      start_q     <= start;
      mode_r      <= mode_nx;
      seed_r      <= seed_nx;
      len_r       <= len_nx;
      word_cnt    <= word_cnt_nx;
      gap_cnt     <= gap_cnt_nx;
      rep_left    <= rep_nx;
      abort_flag  <= abort_nx;
      axiov       <= axiov_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      burst_count <= count_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    mode_nx     = mode_r;
    seed_nx     = seed_r;
    len_nx      = len_r;
    word_cnt_nx = word_cnt;
    gap_cnt_nx  = gap_cnt;
    rep_nx      = rep_left;
    abort_nx    = abort_flag;
    axiov_nx    = axiov;
    busy_nx     = busy;
    done_nx     = 1'b0;
    count_nx    = burst_count;
    load        = 1'b0;
    adv         = 1'b0;
    len_eff     = (len > MAX_LEN) ? MAX_LEN : len;

    case (state)
      S_IDLE: begin
        axiov_nx = 1'b0;
        busy_nx  = 1'b0;
        // busy is still high in the done cycle, which blocks an immediate retrigger
        if (start && !start_q && !busy && len != '0) begin
          mode_nx     = burst_mode_t'(mode);
          seed_nx     = seed;
          len_nx      = len_eff;
          word_cnt_nx = len_eff - LW'(1);
          rep_nx      = (repeat_n == 8'd0) ? 8'd0 : repeat_n - 8'd1;
          abort_nx    = 1'b0;
          axiov_nx    = 1'b1;
          busy_nx     = 1'b1;
          load        = 1'b1;
          state_nx    = S_SEND;
        end
      end
      S_SEND: begin
        if (word_cnt == '0) begin
          count_nx = burst_count + 16'd1;
          axiov_nx = 1'b0;
          if (rep_left != 8'd0 && !(abort_flag || abort)) begin
            gap_cnt_nx = GAP_LAST;
            state_nx   = S_GAP;
          end else begin
            done_nx  = 1'b1;
            state_nx = S_IDLE;
          end
        end else begin
          adv         = 1'b1;
          word_cnt_nx = word_cnt - LW'(1);
          abort_nx    = abort_flag | abort;
        end
      end
      S_GAP: begin
        if (abort) begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end else if (gap_cnt == '0) begin
          word_cnt_nx = len_r - LW'(1);
          rep_nx      = rep_left - 8'd1;
          axiov_nx    = 1'b1;
          load        = 1'b1;
          state_nx    = S_SEND;
        end else begin
          gap_cnt_nx = gap_cnt - GW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The first load happens in the same edge that latches mode/seed, so use the live inputs then.
  assign pat_mode = (state == S_IDLE) ? burst_mode_t'(mode) : mode_r;
  assign pat_seed = (state == S_IDLE) ? seed : seed_r;

  burst_pattern_gen #(.DATA_SIZE(DATA_SIZE)) u_pattern (
    .clk  (clk),
    .rst  (rst),
    .mode (pat_mode),
    .seed (pat_seed),
    .load (load),
    .adv  (adv),
    .word (axiod)
  );

endmodule

// File: doc/udp_burst_gen.md
# udp_burst_gen

Parametrised payload burst generator feeding the `axiiv`/`axiid` input of `network_stack_tx`. On a rising edge of `start` it emits one or more back-to-back bursts of `DATA_SIZE`-bit words, one word per clock, each burst becoming one UDP frame. Word count, repeat count, inter-burst gap and data pattern are runtime or parameter controlled, replacing the fixed seven-word button-triggered test sequence used in bring-up. It runs on the `eth_refclk` domain beside the RX/TX stacks.

## Interface

**Parameters**

- `DATA_SIZE`, default 16: word width; supported values are 8, 16 and 32.
- `MAX_WORDS`, default 64: maximum words per burst.
- `GAP_CYCLES`, default 32: idle cycles between repeated bursts, at least 1. The gap lets the TX stack close a frame.
- `LW`, default `$clog2(MAX_WORDS+1)`: width of `len`.

**Ports**

- `clk` in 1: `eth_refclk`; single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: trigger level; the block acts on its rising edge.
- `abort` in 1: stop request, level sampled.
- `mode` in 2: pattern select. 0 CONST, 1 INC, 2 LFSR, 3 TABLE.
- `len` in LW: words per burst.
- `repeat_n` in 8: bursts per trigger.
- `seed` in DATA_SIZE: pattern seed.
- `axiov` out 1: word valid, to `network_stack_tx.axiiv`.
- `axiod` out DATA_SIZE: word, to `network_stack_tx.axiid`.
- `busy` out 1: a trigger is in progress.
- `done` out 1: one-cycle pulse when a trigger finishes.
- `burst_count` out 16: number of completed bursts; wraps.

## Operation

- **States.** IDLE, SEND, GAP. All outputs are registered.
- **Reset.** On `rst`: state IDLE, `axiov`=0, `axiod`=0, `busy`=0, `done`=0, `burst_count`=0, and the start edge register is cleared.
- **Trigger in IDLE.** `start`=1 while previous-`start`=0 latches `mode`, `len`, `repeat_n` and `seed`.
  - `len`=0: the trigger is ignored; no `busy`, no `done`.
  - `len`>MAX_WORDS: clamped to MAX_WORDS.
  - `repeat_n`=0: treated as 1.
  - Otherwise go to SEND.
- **SEND.** `axiov`=1 for exactly `len` consecutive cycles. After the last word:
  - `burst_count` increments.
  - If bursts remain and no abort is pending, go to GAP.
  - Otherwise go to IDLE and pulse `done`.
- **GAP.** `axiov`=0 for exactly GAP_CYCLES cycles, then return to SEND.
- **Patterns.** The pattern restarts at word 0 for every burst.
  - CONST: every word = `seed`.
  - INC: `seed`+i, modulo 2^DATA_SIZE.
  - LFSR: word 0 = `seed` (a seed of 0 is replaced by 1). Each following word is one Galois step using the package tap constant; for DATA_SIZE=16 the taps are 16'hB400.
  - TABLE: cycles ABCD, 6969, FFFF, 0420, replicated or truncated to DATA_SIZE, restarting at ABCD each burst.
- **Abort.**
  - During SEND: a sticky abort flag is set. The current burst completes in full (frames are never truncated), then the block goes to IDLE and pulses `done`.
  - During GAP: the block goes to IDLE next cycle and pulses `done`.
  - In IDLE: ignored.
- **Start while busy.** Ignored. The edge register still tracks `start`, so a level held high across completion does not retrigger.
- **Mid-operation reset.** Asynchronous; `axiov` drops immediately. No `done` pulse.

## Timing

- Rising edge sampled at cycle t: first `axiov`=1 at t+1 with word 0. Latency is 1 cycle.
- `busy`=1 from t+1 through the cycle in which `done`=1, inclusive.
- The last word of the final burst is at t+len. At t+len+1: `axiov`=0, `done`=1, `busy`=1. At t+len+2: `busy`=0.
- `axiod` holds its last value while `axiov`=0.
- The earliest retrigger is a rising edge at t+len+2.
- Between bursts: last word at cycle c, the next burst's word 0 at c+GAP_CYCLES+1.
- `burst_count` updates in the cycle after each burst's last word.

## Configuration

- Macro `UDP_BURST_LFSR_EN`.
  - Defined: LFSR mode, the LFSR register and the tap logic are compiled in.
  - Undefined: none of that logic exists. `mode`=2 behaves exactly as CONST.

## Structure

- Package `udp_burst_pkg` holds:
  - the `burst_mode_t` enum (CONST/INC/LFSR/TABLE);
  - the `burst_state_t` enum (IDLE/SEND/GAP);
  - the `TABLE_WORDS` constant array;
  - the `lfsr_taps(width)` constant function returning taps for widths 8, 16 and 32.
- Sub-module `burst_pattern_gen` takes mode, seed, a load strobe and an advance strobe, and outputs the current word. The top FSM owns the counters, gap timer and handshake.

## Test plan

- **Single INC burst.** `len`=5, `repeat_n`=1, `seed`=16'hFFFE, mode INC → `axiod` = FFFE, FFFF, 0000, 0001, 0002 on consecutive cycles. `done` follows 1 cycle later; `burst_count`=1.
- **Repeated TABLE bursts.** `len`=6, `repeat_n`=3, GAP_CYCLES=32 → three bursts of ABCD, 6969, FFFF, 0420, ABCD, 6969, each separated by exactly 32 low cycles. `burst_count`=3, one `done` pulse.
- **Abort mid-SEND.** Abort at word 2 of burst 1 of 4, `len`=8 → all 8 words are sent, no GAP is entered, `done` pulses, `burst_count`=1.
- **Edge cases.**
  - `len`=0 → no `axiov`, no `busy`.
  - `len`=200 with MAX_WORDS=64 → exactly 64 words.
  - `start` held high across `done` → no second burst.
- **LFSR.** `seed`=0, mode LFSR, `len`=3 → 0001, B400, 5A00.
  - Without `UDP_BURST_LFSR_EN`: the same stimulus gives 0000, 0000, 0000.
- **Reset mid-GAP.** Assert `rst` during GAP → all outputs are 0 immediately, no `done`, and the next trigger behaves normally.
